animation_scheduler: RTL and testbench
======================================

# animation_scheduler

Playback controller for the seven-segment animation datapath. It owns the animation index, the speed compare value and the run enable, and it arbitrates between manual button commands and an automatic playlist. In auto mode it advances the animation after a configured number of complete animation loops. It sits between the debounced button pulses and the seg7/digit-counter datapath, and replaces the ad-hoc animation and compare registers in the top level.

## Interface
- ANI_BIT, 6, animation index width
- ANI_MAX, 50, highest animation index
- COUNTER_BIT, 25, compare width
- COMP_DEFAULT, 10_000_000, reset compare value (1 s at 10 MHz)
- COMP_MIN, 1_000_000, lowest legal compare
- COMP_MAX, 19_000_000, highest legal compare
- COMP_STEP, 1_000_000, speed step

Ports:
- clk  in  1  system clock, 10 MHz
- reset  in  1  asynchronous, active-high
- inc_ani  in  1  one-cycle pulse, next animation
- dec_ani  in  1  one-cycle pulse, previous animation
- inc_speed  in  1  one-cycle pulse, compare += COMP_STEP
- dec_speed  in  1  one-cycle pulse, compare -= COMP_STEP
- mode_tgl  in  1  one-cycle pulse, toggle manual/auto
- pause_tgl  in  1  one-cycle pulse, toggle pause
- wrap  in  1  one-cycle pulse from the digit counter when digit wraps to 0
- loops_cfg  in  4  loops per animation in auto mode; 0 is treated as 1
- animation  out  ANI_BIT  current animation index
- compare  out  COUNTER_BIT  digit-step period
- run  out  1  datapath counter enable
- auto_mode  out  1  auto playlist selected
- change_strobe  out  1  one-cycle pulse when animation changes; the datapath clears counter and digit
- state  out  2  FSM state, for debug

## Operation
- States: MANUAL=0, AUTO=1, SWITCH=2, PAUSE=3. All outputs are registered or decoded from registers.
- Reset values: state MANUAL, animation 0, compare COMP_DEFAULT, loop_cnt 0, auto_mode 0, change_strobe 0. run=1 because run = (state != PAUSE).
- Per-cycle command priority: pause_tgl > mode_tgl > inc_ani > dec_ani > wrap. Lower-priority commands in the same cycle are dropped.
- Speed commands are handled in every state, independent of the priority chain.
  - inc_speed has priority over dec_speed.
  - Increment only if compare + COMP_STEP <= COMP_MAX. Decrement only if compare - COMP_STEP >= COMP_MIN.
  - Otherwise compare holds (saturating; never wraps).
- Animation step:
  - inc: ANI_MAX wraps to 0, else +1.
  - dec: 0 wraps to ANI_MAX, else -1.
  - Every step clears loop_cnt and sets change_strobe for exactly one cycle, in the same edge as the animation update.
- MANUAL:
  - pause_tgl -> PAUSE.
  - mode_tgl -> AUTO, with auto_mode=1 and loop_cnt=0.
  - inc/dec_ani steps the animation.
  - wrap is ignored.
- AUTO:
  - pause_tgl -> PAUSE.
  - mode_tgl -> MANUAL, with auto_mode=0.
  - inc/dec_ani steps the animation and stays in AUTO.
  - On wrap: if loop_cnt >= eff_loops-1 (eff_loops = loops_cfg, or 1 when loops_cfg is 0), go to SWITCH and clear loop_cnt; else loop_cnt+1.
  - loops_cfg is sampled live, so lowering it mid-run triggers a switch on the next wrap.
- SWITCH: lasts one cycle.
  - Animation performs an inc step (with wrap) and change_strobe is set, then the FSM returns to AUTO.
  - pause_tgl, mode_tgl, inc/dec_ani and wrap arriving in SWITCH are dropped.
- PAUSE:
  - run=0.
  - pause_tgl returns to AUTO if auto_mode=1, else to MANUAL.
  - mode_tgl toggles auto_mode and stays in PAUSE.
  - inc/dec_ani still steps the animation (preview).
  - wrap is ignored.
- loop_cnt: 4 bits, cleared on entering AUTO from MANUAL and on any animation change.

## Timing
- Manual step: a pulse sampled at edge N gives animation and change_strobe updated at edge N; change_strobe is low again after edge N+1.
- Auto switch: the final wrap is sampled at edge N and the state becomes SWITCH. At edge N+1 the animation increments and change_strobe goes high for one cycle.
- Pause: pause_tgl at edge N drops run after edge N. Resume gives run=1 after that edge.
- Speed: compare updates at the sampling edge; the datapath sees the new value in the next cycle.
- Reset mid-SWITCH or mid-PAUSE forces all reset values immediately (asynchronous); no pending step survives.

## Test plan
- Reset -> animation=0, compare=10_000_000, run=1, auto_mode=0, state=0, change_strobe=0.
- From MANUAL at 0: dec_ani -> animation=50 and change_strobe high for 1 cycle. Then inc_ani -> 0. Simultaneous inc_ani and dec_ani at 5 -> 6.
- Speed saturation: 9 inc_speed pulses -> 19_000_000; a 10th -> stays 19_000_000. 18 dec_speed pulses -> 1_000_000; one more -> stays 1_000_000.
- Auto with loops_cfg=3 from animation 7:
  - mode_tgl, then 3 wrap pulses -> SWITCH one cycle after the third, animation=8 one cycle later, change_strobe pulsed once.
  - loops_cfg=0 -> every wrap advances.
- Auto interaction:
  - wrap and inc_ani in the same cycle -> inc wins and loop_cnt=0.
  - inc_ani during SWITCH -> dropped; animation advances by 1 only.
  - At animation 50, a switch -> 0.
- Pause from AUTO: run=0; wrap pulses do not change loop_cnt; mode_tgl -> auto_mode=0; pause_tgl -> state MANUAL, run=1. Assert reset while paused -> all reset values.

Source files
------------

// File: rtl/animation_scheduler.sv
// animation_scheduler
//
// Playback controller for the seven-segment animation datapath. Owns the
// animation index, the digit-step compare value and the run enable, and
// arbitrates between manual button commands and the automatic playlist.
// In auto mode the animation advances after loops_cfg complete loops.
//
// Ports:
//   clk            system clock (10 MHz)
//   reset          asynchronous, active-high reset
//   inc_ani        pulse: next animation
//   dec_ani        pulse: previous animation
//   inc_speed      pulse: compare += COMP_STEP (saturating)
//   dec_speed      pulse: compare -= COMP_STEP (saturating)
//   mode_tgl       pulse: toggle manual/auto playlist
//   pause_tgl      pulse: toggle pause
//   wrap           pulse: digit counter wrapped to 0 (one animation loop done)
//   loops_cfg      loops per animation in auto mode (0 behaves as 1)
//   animation      current animation index
//   compare        digit-step period
//   run            datapath counter enable (low only while paused)
//   auto_mode      auto playlist selected
//   change_strobe  one-cycle pulse on every animation change
//   state          FSM state for debug (0 MANUAL, 1 AUTO, 2 SWITCH, 3 PAUSE)

module animation_scheduler #(
   parameter int ANI_BIT      = 6,
   parameter int ANI_MAX      = 50,
   parameter int COUNTER_BIT  = 25,
   parameter int COMP_DEFAULT = 10_000_000,
   parameter int COMP_MIN     = 1_000_000,
   parameter int COMP_MAX     = 19_000_000,
   parameter int COMP_STEP    = 1_000_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inc_ani,
   input  logic                   dec_ani,
   input  logic                   inc_speed,
   input  logic                   dec_speed,
   input  logic                   mode_tgl,
   input  logic                   pause_tgl,
   input  logic                   wrap,
   input  logic [3:0]             loops_cfg,
   output logic [ANI_BIT-1:0]     animation,
   output logic [COUNTER_BIT-1:0] compare,
   output logic                   run,
   output logic                   auto_mode,
   output logic                   change_strobe,
   output logic [1:0]             state
);

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      AUTO   = 2'd1,
      SWITCH = 2'd2,
      PAUSE  = 2'd3
   } state_t;

   localparam logic [ANI_BIT-1:0]     ANI_LAST  = ANI_BIT'(ANI_MAX);
   localparam logic [ANI_BIT-1:0]     ANI_ONE   = ANI_BIT'(1);
   localparam logic [COUNTER_BIT-1:0] CMP_RESET = COUNTER_BIT'(COMP_DEFAULT);
   localparam logic [COUNTER_BIT-1:0] CMP_STEP  = COUNTER_BIT'(COMP_STEP);
   // One extra bit so the headroom test cannot overflow.
   localparam logic [COUNTER_BIT:0]   CMP_UP_LIM = (COUNTER_BIT+1)'(COMP_MAX - COMP_STEP);
   localparam logic [COUNTER_BIT:0]   CMP_DN_LIM = (COUNTER_BIT+1)'(COMP_MIN + COMP_STEP);

   state_t                   fsm_state, state_d;
   logic [ANI_BIT-1:0]       ani_q, ani_d;
   logic [COUNTER_BIT-1:0]   compare_q, compare_d;
   logic [3:0]               loop_cnt, loop_d;
   logic                     auto_q, auto_d;
   logic                     strobe_q, strobe_d;
   logic [3:0]               loop_last;
   logic [COUNTER_BIT:0]     cmp_ext;

   function automatic logic [ANI_BIT-1:0] ani_up(input logic [ANI_BIT-1:0] a);
      return (a == ANI_LAST) ? '0 : a + ANI_ONE;
   endfunction

   function automatic logic [ANI_BIT-1:0] ani_down(input logic [ANI_BIT-1:0] a);
      return (a == '0) ? ANI_LAST : a - ANI_ONE;
   endfunction

   // loops_cfg of 0 behaves like 1: switch on every wrap.
   assign loop_last = (loops_cfg == 4'd0) ? 4'd0 : loops_cfg - 4'd1;
   assign cmp_ext   = {1'b0, compare_q};

   // State and data registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_state <= MANUAL;
         ani_q     <= '0;
         compare_q <= CMP_RESET;
         loop_cnt  <= '0;
         auto_q    <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         fsm_state <= state_d;
         ani_q     <= ani_d;
         compare_q <= compare_d;
         loop_cnt  <= loop_d;
         auto_q    <= auto_d;
         strobe_q  <= strobe_d;
      end
   end

   // Next-state and next-data logic
   always_comb begin
      state_d   = fsm_state;
      ani_d     = ani_q;
      compare_d = compare_q;
      loop_d    = loop_cnt;
      auto_d    = auto_q;
      strobe_d  = 1'b0;

      // Speed runs outside the command priority chain, in every state.
      if (inc_speed) begin
         if (cmp_ext <= CMP_UP_LIM)
            compare_d = compare_q + CMP_STEP;
      end else if (dec_speed) begin
         if (cmp_ext >= CMP_DN_LIM)
            compare_d = compare_q - CMP_STEP;
      end

      unique case (fsm_state)
         MANUAL: begin
            if (pause_tgl) begin
               state_d = PAUSE;
            end else if (mode_tgl) begin
               state_d = AUTO;
               auto_d  = 1'b1;
               loop_d  = '0;
            end else if (inc_ani) begin
               ani_d    = ani_up(ani_q);
               loop_d   = '0;
               strobe_d = 1'b1;
            end else if (dec_ani) begin
               ani_d    = ani_down(ani_q);
               loop_d   = '0;
               strobe_d = 1'b1;
            end
         end
         AUTO: begin
            if (pause_tgl) begin
               state_d = PAUSE;
            end else if (mode_tgl) begin
               state_d = MANUAL;
               auto_d  = 1'b0;
            end else if (inc_ani) begin
               ani_d    = ani_up(ani_q);
               loop_d   = '0;
               strobe_d = 1'b1;
            end else if (dec_ani) begin
               ani_d    = ani_down(ani_q);
               loop_d   = '0;
               strobe_d = 1'b1;
            end else if (wrap) begin
               // loops_cfg is live, so a lowered limit switches on the next wrap.
               if (loop_cnt >= loop_last) begin
                  state_d = SWITCH;
                  loop_d  = '0;
               end else begin
                  loop_d = loop_cnt + 4'd1;
               end
            end
         end
         SWITCH: begin
            // All commands arriving here are dropped.
            state_d  = AUTO;
            ani_d    = ani_up(ani_q);
            loop_d   = '0;
            strobe_d = 1'b1;
         end
         PAUSE: begin
            if (pause_tgl) begin
               state_d = auto_q ? AUTO : MANUAL;
            end else if (mode_tgl) begin
               auto_d = ~auto_q;
            end else if (inc_ani) begin
               ani_d    = ani_up(ani_q);
               loop_d   = '0;
               strobe_d = 1'b1;
            end else if (dec_ani) begin
               ani_d    = ani_down(ani_q);
               loop_d   = '0;
               strobe_d = 1'b1;
            end
         end
         default: state_d = MANUAL;
      endcase
   end

   // Output decode
   always_comb begin
      run = (fsm_state != PAUSE);
   end

   assign animation     = ani_q;
   assign compare       = compare_q;
   assign auto_mode     = auto_q;
   assign change_strobe = strobe_q;
   assign state         = fsm_state;

endmodule

// File: tb/tb_animation_scheduler.sv
// tb_animation_scheduler
//
// Directed bench for animation_scheduler. Inputs are driven 1 time unit
// after a rising edge and outputs are checked at the same point, so every
// check sees the result of the edge just taken.

module tb_animation_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        inc_ani, dec_ani, inc_speed, dec_speed;
   logic        mode_tgl, pause_tgl, wrap;
   logic [3:0]  loops_cfg;
   logic [5:0]  animation;
   logic [24:0] compare;
   logic        run, auto_mode, change_strobe;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   animation_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .inc_ani       (inc_ani),
      .dec_ani       (dec_ani),
      .inc_speed     (inc_speed),
      .dec_speed     (dec_speed),
      .mode_tgl      (mode_tgl),
      .pause_tgl     (pause_tgl),
      .wrap          (wrap),
      .loops_cfg     (loops_cfg),
      .animation     (animation),
      .compare       (compare),
      .run           (run),
      .auto_mode     (auto_mode),
      .change_strobe (change_strobe),
      .state         (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inc_ani = 0; dec_ani = 0; inc_speed = 0; dec_speed = 0;
      mode_tgl = 0; pause_tgl = 0; wrap = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ani"},    32'(animation), 0);
      check({tag, "_cmp"},    32'(compare), 10_000_000);
      check({tag, "_run"},    32'(run), 1);
      check({tag, "_auto"},   32'(auto_mode), 0);
      check({tag, "_state"},  32'(state), 0);
      check({tag, "_strobe"}, 32'(change_strobe), 0);
   endtask

   initial begin
      clear_inputs();
      loops_cfg = 4'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_values("reset");

      // Manual stepping with wrap-around at both ends
      dec_ani = 1; tick(); dec_ani = 0;
      check("dec_wrap_ani", 32'(animation), 50);
      check("dec_wrap_strobe", 32'(change_strobe), 1);
      tick();
      check("strobe_one_cycle", 32'(change_strobe), 0);
      inc_ani = 1; tick(); inc_ani = 0;
      check("inc_wrap_ani", 32'(animation), 0);
      check("inc_wrap_strobe", 32'(change_strobe), 1);
      for (int i = 0; i < 5; i++) begin
         inc_ani = 1; tick(); inc_ani = 0;
      end
      check("ani_at_5", 32'(animation), 5);
      inc_ani = 1; dec_ani = 1; tick(); clear_inputs();
      check("inc_beats_dec", 32'(animation), 6);
      wrap = 1; tick(); wrap = 0;
      check("manual_wrap_ignored_state", 32'(state), 0);

      // Speed saturation
      for (int i = 0; i < 9; i++) begin
         inc_speed = 1; tick(); inc_speed = 0;
      end
      check("speed_max", 32'(compare), 19_000_000);
      inc_speed = 1; tick(); inc_speed = 0;
      check("speed_max_hold", 32'(compare), 19_000_000);
      for (int i = 0; i < 18; i++) begin
         dec_speed = 1; tick(); dec_speed = 0;
      end
      check("speed_min", 32'(compare), 1_000_000);
      dec_speed = 1; tick(); dec_speed = 0;
      check("speed_min_hold", 32'(compare), 1_000_000);
      inc_speed = 1; dec_speed = 1; tick(); clear_inputs();
      check("inc_speed_wins", 32'(compare), 2_000_000);

      // Auto mode, three loops per animation, starting from 7
      inc_ani = 1; tick(); inc_ani = 0;
      check("ani_at_7", 32'(animation), 7);
      loops_cfg = 4'd3;
      mode_tgl = 1; tick(); mode_tgl = 0;
      check("auto_state", 32'(state), 1);
      check("auto_flag", 32'(auto_mode), 1);
      wrap = 1; tick(); wrap = 0;
      wrap = 1; tick(); wrap = 0;
      check("loops_two", 32'(dut.loop_cnt), 2);
      check("still_auto", 32'(state), 1);
      wrap = 1; tick(); wrap = 0;
      check("switch_state", 32'(state), 2);
      check("switch_ani_pending", 32'(animation), 7);
      check("switch_no_strobe_yet", 32'(change_strobe), 0);
      tick();
      check("after_switch_state", 32'(state), 1);
      check("after_switch_ani", 32'(animation), 8);
      check("after_switch_strobe", 32'(change_strobe), 1);
      tick();
      check("after_switch_strobe_low", 32'(change_strobe), 0);

      // loops_cfg of 0: every wrap advances
      loops_cfg = 4'd0;
      wrap = 1; tick(); wrap = 0;
      check("cfg0_switch", 32'(state), 2);
      tick();
      check("cfg0_ani", 32'(animation), 9);

      // wrap and inc_ani together: inc wins, loop count cleared
      loops_cfg = 4'd3;
      wrap = 1; tick(); wrap = 0;
      check("one_loop", 32'(dut.loop_cnt), 1);
      wrap = 1; inc_ani = 1; tick(); clear_inputs();
      check("wrap_inc_ani", 32'(animation), 10);
      check("wrap_inc_loops", 32'(dut.loop_cnt), 0);
      check("wrap_inc_state", 32'(state), 1);

      // inc_ani during SWITCH is dropped
      loops_cfg = 4'd0;
      wrap = 1; tick(); wrap = 0;
      check("sw2_state", 32'(state), 2);
      inc_ani = 1; tick(); inc_ani = 0;
      check("sw_drop_ani", 32'(animation), 11);
      tick();
      check("sw_drop_ani_hold", 32'(animation), 11);

      // Automatic switch from the last animation wraps to 0
      for (int i = 0; i < 12; i++) begin
         dec_ani = 1; tick(); dec_ani = 0;
      end
      check("auto_ani_50", 32'(animation), 50);
      check("auto_dec_state", 32'(state), 1);
      wrap = 1; tick(); wrap = 0;
      tick();
      check("switch_wrap_ani", 32'(animation), 0);

      // Pause from auto
      loops_cfg = 4'd3;
      wrap = 1; tick(); wrap = 0;
      pause_tgl = 1; tick(); pause_tgl = 0;
      check("pause_state", 32'(state), 3);
      check("pause_run", 32'(run), 0);
      for (int i = 0; i < 3; i++) begin
         wrap = 1; tick(); wrap = 0;
      end
      check("pause_loops_hold", 32'(dut.loop_cnt), 1);
      check("pause_state_hold", 32'(state), 3);
      mode_tgl = 1; tick(); mode_tgl = 0;
      check("pause_mode_auto", 32'(auto_mode), 0);
      check("pause_mode_state", 32'(state), 3);
      pause_tgl = 1; tick(); pause_tgl = 0;
      check("resume_state", 32'(state), 0);
      check("resume_run", 32'(run), 1);

      // Preview step while paused, then asynchronous reset
      pause_tgl = 1; tick(); pause_tgl = 0;
      inc_speed = 1; inc_ani = 1; tick(); clear_inputs();
      check("preview_ani", 32'(animation), 1);
      check("preview_strobe", 32'(change_strobe), 1);
      check("pause_speed", 32'(compare), 3_000_000);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      tick();
      reset = 1'b0;
      tick();
      check("post_reset_state", 32'(state), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
